// File: rtl/iob_cache_line_fill_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iob_cache_line_fill_pkg
// Description : Shared types and width helpers for the cache line-fill
//               channel and its wrap counter.
// Revision    : 1.0 - initial release
// ============================================================================
package iob_cache_line_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAIL = 2'd2
  } state_t;

  // Number of index bits selecting a back-end beat within one cache line.
  function automatic int calc_line2be_w(input int word_offset_w,
                                        input int fe_data_w,
                                        input int be_data_w);
    return word_offset_w - $clog2(be_data_w / fe_data_w);
  endfunction

  // Physical width of a beat index; never narrower than one bit.
  function automatic int calc_idx_w(input int line2be_w);
    return (line2be_w > 0) ? line2be_w : 1;
  endfunction

endpackage : iob_cache_line_fill_pkg
`default_nettype wire

// File: rtl/iob_cache_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : iob_cache_wrap_counter
// Description : Beat sequencer for a cache line burst. Loads a start beat,
//               counts accepted beats and emits the wrapped beat index.
// Revision    : 1.0 - initial release
// Ports       : clk_i, reset_i - clock, asynchronous active-high reset
//               load_i         - latch start_i and clear the beat count
//               start_i        - first beat of the burst
//               inc_i          - one beat accepted
//               idx_o          - (start + count) mod 2^WIDTH
//               first_o        - no beat accepted yet
//               last_o         - current beat is the final one of the line
// ============================================================================
module iob_cache_wrap_counter #(
  parameter  int WIDTH = 2,
  localparam int IW    = (WIDTH > 0) ? WIDTH : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          load_i,
  input  logic [IW-1:0] start_i,
  input  logic          inc_i,
  output logic [IW-1:0] idx_o,
  output logic          first_o,
  output logic          last_o
);

  generate
    if (WIDTH > 0) begin : g_wide
      logic [IW-1:0] start_r;
      logic [IW-1:0] count_r;

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          start_r <= '0;
          count_r <= '0;
        end else if (load_i) begin
          start_r <= start_i;
          count_r <= '0;
        end else if (inc_i) begin
          count_r <= count_r + 1'b1;
        end
      end

      // Truncating add gives the wrap-around for free.
      assign idx_o   = start_r + count_r;
      assign first_o = (count_r == '0);
      assign last_o  = &count_r;
    end else begin : g_single
      // A one-beat line: the only beat is both first and last.
      logic unused_single;
      assign unused_single = ^{clk_i, reset_i, load_i, start_i, inc_i};
      assign idx_o   = '0;
      assign first_o = 1'b1;
      assign last_o  = 1'b1;
    end
  endgenerate

endmodule : iob_cache_wrap_counter
`default_nettype wire

// File: rtl/iob_cache_line_fill.sv
`default_nettype none
// ============================================================================
// Module      : iob_cache_line_fill
// Description : Fetches one cache line from the back-end memory as a burst
//               of BE words (optionally critical-word-first) and writes each
//               beat to the data memory through registered write outputs.
// Revision    : 1.0 - initial release
// Ports       : clk_i, reset_i     - clock, asynchronous active-high reset
//               replace_valid_i    - line fill request (sampled in IDLE)
//               replace_addr_i     - miss address above the BE byte offset
//               replace_o          - fill in progress
//               critical_o         - pulse with write of first-fetched beat
//               done_o             - pulse on the last tail cycle
//               read_valid_o/addr/rdata - data-memory write port
//               be_addr_o/valid_o, be_ack_i, be_rdata_i - back-end port
// ============================================================================
module iob_cache_line_fill
  import iob_cache_line_fill_pkg::*;
#(
  parameter  int FE_ADDR_W     = 32,
  parameter  int FE_DATA_W     = 32,
  parameter  int BE_ADDR_W     = 32,
  parameter  int BE_DATA_W     = 64,
  parameter  int WORD_OFFSET_W = 3,
  parameter  int CWF           = 1,
  parameter  int TAIL_CYCLES   = 1,
  localparam int BE_NBYTES_W   = $clog2(BE_DATA_W / 8),
  localparam int LINE2BE_W     = calc_line2be_w(WORD_OFFSET_W, FE_DATA_W, BE_DATA_W),
  localparam int IDX_W         = calc_idx_w(LINE2BE_W),
  localparam int REQ_W         = FE_ADDR_W - BE_NBYTES_W
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 replace_valid_i,
  input  logic [REQ_W-1:0]     replace_addr_i,
  output logic                 replace_o,
  output logic                 critical_o,
  output logic                 done_o,
  output logic                 read_valid_o,
  output logic [IDX_W-1:0]     read_addr_o,
  output logic [BE_DATA_W-1:0] read_rdata_o,
  output logic [BE_ADDR_W-1:0] be_addr_o,
  output logic                 be_valid_o,
  input  logic                 be_ack_i,
  input  logic [BE_DATA_W-1:0] be_rdata_i
);

  localparam int         TAG_W     = REQ_W - LINE2BE_W;
  localparam logic [3:0] TAIL_INIT = 4'(TAIL_CYCLES - 1);

  state_t            state_r, state_next;
  logic [TAG_W-1:0]  tag_r;
  logic [3:0]        tail_r;
  logic [IDX_W-1:0]  start;
  logic [IDX_W-1:0]  idx;
  logic              first_beat;
  logic              last_beat;
  logic              accept;
  logic              beat_ack;
  logic              tail_load;
  logic [FE_ADDR_W-1:0] line_addr;

  // Start beat of the burst: the requested beat in wrap mode, else beat 0.
  generate
    if ((CWF != 0) && (LINE2BE_W > 0)) begin : g_cwf
      assign start = replace_addr_i[IDX_W-1:0];
    end else begin : g_linear
      logic unused_low;
      assign unused_low = ^replace_addr_i[IDX_W-1:0];
      assign start = '0;
    end
  endgenerate

  iob_cache_wrap_counter #(
    .WIDTH (LINE2BE_W)
  ) u_wrap_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (accept),
    .start_i (start),
    .inc_i   (beat_ack),
    .idx_o   (idx),
    .first_o (first_beat),
    .last_o  (last_beat)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_next;
  end

  always_comb begin
    state_next = state_r;
    accept     = 1'b0;
    be_valid_o = 1'b0;
    tail_load  = 1'b0;
    done_o     = 1'b0;
    case (state_r)
      IDLE: begin
        if (replace_valid_i) begin
          accept     = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        be_valid_o = 1'b1;
        // Leaving FILL on the final ack drops be_valid_o next cycle, so no
        // extra request is ever presented.
        if (be_ack_i && last_beat) begin
          tail_load  = 1'b1;
          state_next = TAIL;
        end
      end
      TAIL: begin
        if (tail_r == 4'd0) begin
          done_o     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign beat_ack  = be_valid_o & be_ack_i;
  assign replace_o = (state_r != IDLE);

  // ---------------------------------------------------------------------------
  // Line address latch and tail counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tag_r <= '0;
    end else if (accept) begin
      tag_r <= replace_addr_i[REQ_W-1:LINE2BE_W];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tail_r <= 4'd0;
    end else if (tail_load) begin
      tail_r <= TAIL_INIT;
    end else if ((state_r == TAIL) && (tail_r != 4'd0)) begin
      tail_r <= tail_r - 4'd1;
    end
  end

  // idx is zero for a single-beat line, so OR-ing it in is always safe.
  assign line_addr = (FE_ADDR_W'(tag_r) << (LINE2BE_W + BE_NBYTES_W))
                   | (FE_ADDR_W'(idx) << BE_NBYTES_W);
  assign be_addr_o = BE_ADDR_W'(line_addr);

  // ---------------------------------------------------------------------------
  // Registered data-memory write port (one cycle after each accepted beat)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      read_valid_o <= 1'b0;
      critical_o   <= 1'b0;
      read_addr_o  <= '0;
      read_rdata_o <= '0;
    end else begin
      read_valid_o <= beat_ack;
      critical_o   <= beat_ack & first_beat;
      if (beat_ack) begin
        read_addr_o  <= idx;
        read_rdata_o <= be_rdata_i;
      end
    end
  end

endmodule : iob_cache_line_fill
`default_nettype wire

// File: tb/tb_iob_cache_line_fill.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_cache_line_fill
// Description : Directed bench for the cache line-fill channel. Three
//               instances share one stimulus: A (wrap order, 1 tail cycle),
//               B (linear order, 1 tail cycle), C (wrap order, 3 tail cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_cache_line_fill;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        replace_valid;
  logic [28:0] replace_addr;
  logic        be_ack;
  logic [63:0] be_rdata;

  logic        a_replace, a_critical, a_done, a_rvalid, a_be_valid;
  logic [1:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [31:0] a_be_addr;
  logic        b_replace, b_critical, b_done, b_rvalid, b_be_valid;
  logic [1:0]  b_raddr;
  logic [63:0] b_rdata;
  logic [31:0] b_be_addr;
  logic        c_replace, c_critical, c_done, c_rvalid, c_be_valid;
  logic [1:0]  c_raddr;
  logic [63:0] c_rdata;
  logic [31:0] c_be_addr;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected burst addresses and beat indices, hand computed.
  logic [31:0] ea1 [0:3] = '{32'h24690, 32'h24698, 32'h24680, 32'h24688};
  logic [31:0] eb1 [0:3] = '{32'h24680, 32'h24688, 32'h24690, 32'h24698};
  logic [1:0]  ia1 [0:3] = '{2'd2, 2'd3, 2'd0, 2'd1};
  logic [31:0] ea2 [0:3] = '{32'h15788, 32'h15790, 32'h15798, 32'h15780};
  logic [31:0] eb2 [0:3] = '{32'h15780, 32'h15788, 32'h15790, 32'h15798};
  logic [1:0]  ia2 [0:3] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [63:0] d1  [0:3] = '{64'hA0A0_0000_1111_0000, 64'hA1A1_0000_2222_0001,
                             64'hA2A2_0000_3333_0002, 64'hA3A3_0000_4444_0003};
  logic [63:0] d2  [0:3] = '{64'h0123_4567_89AB_CDE0, 64'hFEDC_BA98_7654_3211,
                             64'h5A5A_5A5A_A5A5_A5A2, 64'hDEAD_BEEF_CAFE_F00D};
  int          gaps[0:3] = '{1, 0, 3, 2};

  iob_cache_line_fill #(.CWF(1), .TAIL_CYCLES(1)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .replace_valid_i(replace_valid),
    .replace_addr_i(replace_addr), .replace_o(a_replace), .critical_o(a_critical),
    .done_o(a_done), .read_valid_o(a_rvalid), .read_addr_o(a_raddr),
    .read_rdata_o(a_rdata), .be_addr_o(a_be_addr), .be_valid_o(a_be_valid),
    .be_ack_i(be_ack), .be_rdata_i(be_rdata));

  iob_cache_line_fill #(.CWF(0), .TAIL_CYCLES(1)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .replace_valid_i(replace_valid),
    .replace_addr_i(replace_addr), .replace_o(b_replace), .critical_o(b_critical),
    .done_o(b_done), .read_valid_o(b_rvalid), .read_addr_o(b_raddr),
    .read_rdata_o(b_rdata), .be_addr_o(b_be_addr), .be_valid_o(b_be_valid),
    .be_ack_i(be_ack), .be_rdata_i(be_rdata));

  iob_cache_line_fill #(.CWF(1), .TAIL_CYCLES(3)) dut_c (
    .clk_i(clk), .reset_i(reset_i), .replace_valid_i(replace_valid),
    .replace_addr_i(replace_addr), .replace_o(c_replace), .critical_o(c_critical),
    .done_o(c_done), .read_valid_o(c_rvalid), .read_addr_o(c_raddr),
    .read_rdata_o(c_rdata), .be_addr_o(c_be_addr), .be_valid_o(c_be_valid),
    .be_ack_i(be_ack), .be_rdata_i(be_rdata));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_i       = 1'b1;
    replace_valid = 1'b0;
    replace_addr  = '0;
    be_ack        = 1'b0;
    be_rdata      = '0;

    // ---------------- reset state ----------------
    tick();
    chk("rst_replace",  64'(a_replace),  64'd0);
    chk("rst_critical", 64'(a_critical), 64'd0);
    chk("rst_done",     64'(a_done),     64'd0);
    chk("rst_rvalid",   64'(a_rvalid),   64'd0);
    chk("rst_raddr",    64'(a_raddr),    64'd0);
    chk("rst_rdata",    a_rdata,         64'd0);
    chk("rst_be_valid", 64'(a_be_valid), 64'd0);
    chk("rst_be_addr",  64'(a_be_addr),  64'd0);
    reset_i = 1'b0;
    tick();

    // ---------------- fill 1: back-to-back acks ----------------
    replace_valid = 1'b1;
    replace_addr  = 29'h48D2;            // tag 0x1234, critical beat 2
    chk("f1_idle_replace", 64'(a_replace), 64'd0);
    tick();
    replace_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("f1_a_be_valid%0d", k), 64'(a_be_valid), 64'd1);
      chk($sformatf("f1_a_be_addr%0d", k),  64'(a_be_addr),  64'(ea1[k]));
      chk($sformatf("f1_b_be_addr%0d", k),  64'(b_be_addr),  64'(eb1[k]));
      chk($sformatf("f1_c_be_addr%0d", k),  64'(c_be_addr),  64'(ea1[k]));
      chk($sformatf("f1_a_replace%0d", k),  64'(a_replace),  64'd1);
      chk($sformatf("f1_a_done%0d", k),     64'(a_done),     64'd0);
      be_ack   = 1'b1;
      be_rdata = d1[k];
      tick();
      chk($sformatf("f1_a_rvalid%0d", k),   64'(a_rvalid),   64'd1);
      chk($sformatf("f1_a_raddr%0d", k),    64'(a_raddr),    64'(ia1[k]));
      chk($sformatf("f1_a_rdata%0d", k),    a_rdata,         d1[k]);
      chk($sformatf("f1_a_critical%0d", k), 64'(a_critical), (k == 0) ? 64'd1 : 64'd0);
      chk($sformatf("f1_b_raddr%0d", k),    64'(b_raddr),    64'(k));
      chk($sformatf("f1_b_critical%0d", k), 64'(b_critical), (k == 0) ? 64'd1 : 64'd0);
      chk($sformatf("f1_c_rvalid%0d", k),   64'(c_rvalid),   64'd1);
    end
    // First TAIL cycle; ack stays high to probe writes outside FILL.
    be_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    chk("f1_a_be_valid_after", 64'(a_be_valid), 64'd0);
    chk("f1_b_be_valid_after", 64'(b_be_valid), 64'd0);
    chk("f1_c_be_valid_after", 64'(c_be_valid), 64'd0);
    chk("f1_a_done",           64'(a_done),     64'd1);
    chk("f1_b_done",           64'(b_done),     64'd1);
    chk("f1_c_done_t0",        64'(c_done),     64'd0);
    chk("f1_a_replace_tail",   64'(a_replace),  64'd1);
    chk("f1_c_replace_t0",     64'(c_replace),  64'd1);
    tick();
    chk("f1_a_replace_idle",   64'(a_replace),  64'd0);
    chk("f1_a_done_idle",      64'(a_done),     64'd0);
    chk("f1_a_rvalid_idle",    64'(a_rvalid),   64'd0);
    chk("f1_b_rvalid_idle",    64'(b_rvalid),   64'd0);
    chk("f1_c_replace_t1",     64'(c_replace),  64'd1);
    chk("f1_c_done_t1",        64'(c_done),     64'd0);
    chk("f1_c_rvalid_t1",      64'(c_rvalid),   64'd0);
    chk("f1_c_be_valid_t1",    64'(c_be_valid), 64'd0);
    tick();
    chk("f1_c_done_t2",        64'(c_done),     64'd1);
    chk("f1_c_replace_t2",     64'(c_replace),  64'd1);
    chk("f1_c_rvalid_t2",      64'(c_rvalid),   64'd0);
    be_ack = 1'b0;
    tick();
    chk("f1_c_replace_idle",   64'(c_replace),  64'd0);
    chk("f1_c_done_idle",      64'(c_done),     64'd0);
    chk("f1_c_rdata_held",     c_rdata,         d1[3]);

    // ---------------- fill 2: ack gaps, request noise ----------------
    replace_valid = 1'b1;
    replace_addr  = 29'h2AF1;            // tag 0xABC, critical beat 1
    tick();
    replace_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        be_ack        = 1'b0;
        be_rdata      = 64'hEEEE_0000_0000_0000 | 64'(g);
        replace_valid = 1'b1;
        replace_addr  = 29'h0BEEF0F;
        tick();
        chk($sformatf("f2_gap_a_be_addr%0d_%0d", k, g), 64'(a_be_addr),  64'(ea2[k]));
        chk($sformatf("f2_gap_b_be_addr%0d_%0d", k, g), 64'(b_be_addr),  64'(eb2[k]));
        chk($sformatf("f2_gap_a_be_valid%0d_%0d", k, g), 64'(a_be_valid), 64'd1);
      end
      replace_valid = 1'b0;
      chk($sformatf("f2_a_be_addr%0d", k), 64'(a_be_addr), 64'(ea2[k]));
      chk($sformatf("f2_c_be_addr%0d", k), 64'(c_be_addr), 64'(ea2[k]));
      be_ack   = 1'b1;
      be_rdata = d2[k];
      tick();
      be_ack   = 1'b0;
      be_rdata = 64'h7777_7777_7777_7777;
      chk($sformatf("f2_a_rvalid%0d", k),   64'(a_rvalid),   64'd1);
      chk($sformatf("f2_a_raddr%0d", k),    64'(a_raddr),    64'(ia2[k]));
      chk($sformatf("f2_a_rdata%0d", k),    a_rdata,         d2[k]);
      chk($sformatf("f2_b_rdata%0d", k),    b_rdata,         d2[k]);
      chk($sformatf("f2_a_critical%0d", k), 64'(a_critical), (k == 0) ? 64'd1 : 64'd0);
    end
    chk("f2_a_done",     64'(a_done),     64'd1);
    chk("f2_a_be_valid", 64'(a_be_valid), 64'd0);
    tick();
    chk("f2_a_idle",     64'(a_replace),  64'd0);
    chk("f2_a_rvalid",   64'(a_rvalid),   64'd0);
    tick();
    tick();
    chk("f2_c_idle",     64'(c_replace),  64'd0);
    chk("f2_b_idle",     64'(b_replace),  64'd0);

    // ---------------- fill 3: reset after the 2nd ack ----------------
    replace_valid = 1'b1;
    replace_addr  = 29'h01DF;            // tag 0x77, critical beat 3
    tick();
    replace_valid = 1'b0;
    be_ack   = 1'b1;
    be_rdata = 64'h3333_0000_0000_0000;
    tick();
    tick();
    chk("f3_pre_rvalid",   64'(a_rvalid),   64'd1);
    chk("f3_pre_be_valid", 64'(a_be_valid), 64'd1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("f3_rst_be_valid", 64'(a_be_valid), 64'd0);
    chk("f3_rst_replace",  64'(a_replace),  64'd0);
    chk("f3_rst_rvalid",   64'(a_rvalid),   64'd0);
    chk("f3_rst_done",     64'(a_done),     64'd0);
    chk("f3_rst_c_valid",  64'(c_be_valid), 64'd0);
    be_ack = 1'b0;
    #2;
    reset_i = 1'b0;
    tick();
    chk("f3_post_done",    64'(a_done),     64'd0);
    chk("f3_post_replace", 64'(a_replace),  64'd0);
    replace_valid = 1'b1;
    tick();
    replace_valid = 1'b0;
    chk("f3_restart_a_addr", 64'(a_be_addr), 64'h0EF8);
    chk("f3_restart_b_addr", 64'(b_be_addr), 64'h0EE0);
    be_ack   = 1'b1;
    be_rdata = 64'h4444_5555_6666_7777;
    tick();
    be_ack = 1'b0;
    chk("f3_restart_a_raddr", 64'(a_raddr),    64'd3);
    chk("f3_restart_a_crit",  64'(a_critical), 64'd1);
    chk("f3_restart_b_raddr", 64'(b_raddr),    64'd0);
    chk("f3_restart_a_rdata", a_rdata,         64'h4444_5555_6666_7777);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_iob_cache_line_fill
`default_nettype wire
